// File: rtl/dma_dimn.sv
// -----------------------------------------------------------------------------
// dma_dimn : N-dimensional DMA address generator.
//
// Accepts one descriptor (base, per-dimension size and signed step) through a
// valid/ready start handshake. It then streams one address per accepted beat,
// with dimension 0 innermost. Each beat carries first/last markers and a
// per-dimension "last" vector for downstream framing.
//
// Ports
//   clk, rst      clock / asynchronous active-high reset
//   base          start address
//   dim_size      size of dim d at [d*SW +: SW]; 0 is treated as 1
//   dim_step      signed step of dim d at [d*STW +: STW]
//   start_valid   descriptor valid
//   start_ready   descriptor accepted on start_valid & start_ready
//   abort         terminate the current transfer (ignored when idle)
//   busy          transfer in progress
//   s_addr        current beat address
//   s_first       first beat of the transfer
//   s_last        final beat of the transfer
//   s_dim_last    bit d: dims 0..d all at their final index
//   s_valid       beat valid
//   s_ready       beat accepted on s_valid & s_ready
// -----------------------------------------------------------------------------
module dma_dimn #(
    parameter int AW   = 11,
    parameter int NDIM = 3,
    parameter int SW   = 4,
    parameter int STW  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AW-1:0]         base,
    input  logic [NDIM*SW-1:0]    dim_size,
    input  logic [NDIM*STW-1:0]   dim_step,
    input  logic                  start_valid,
    output logic                  start_ready,
    input  logic                  abort,
    output logic                  busy,
    output logic [AW-1:0]         s_addr,
    output logic                  s_first,
    output logic                  s_last,
    output logic [NDIM-1:0]       s_dim_last,
    output logic                  s_valid,
    input  logic                  s_ready
);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t              state_q, state_d;
    logic [SW-1:0]       idx_q  [NDIM];
    logic [SW-1:0]       idx_d  [NDIM];
    logic [SW-1:0]       lim_q  [NDIM];   // final index of each dim (size-1, size 0 read as 1)
    logic [SW-1:0]       lim_d  [NDIM];
    logic [AW-1:0]       step_q [NDIM];   // step sign-extended to address width
    logic [AW-1:0]       step_d [NDIM];
    // rb_q[d] is the current address with dims 0..d-1 at index 0; rb_q[0] is the beat address.
    logic [AW-1:0]       rb_q   [NDIM];
    logic [AW-1:0]       rb_d   [NDIM];
    logic                first_q, first_d;
    logic                last_q, last_d;
    logic [NDIM-1:0]     dlast_q, dlast_d;

    logic                carry_found;
    int                  k_sel;
    logic [AW-1:0]       nxt_addr;
    logic                upd;
    logic                fin_acc;

    // NOTE: every variable assigned in this block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lim_d       = lim_q;
        step_d      = step_q;
        rb_d        = rb_q;
        first_d     = first_q;
        last_d      = last_q;
        dlast_d     = dlast_q;
        upd         = 1'b0;
        carry_found = 1'b0;
        k_sel       = 0;
        fin_acc     = 1'b1;

        // Lowest dimension that is not yet at its final index is the one to advance.
        for (int d = 0; d < NDIM; d++) begin
            if (!carry_found && (idx_q[d] != lim_q[d])) begin
                carry_found = 1'b1;
                k_sel       = d;
            end
        end
        nxt_addr = rb_q[k_sel] + step_q[k_sel];

        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    for (int d = 0; d < NDIM; d++) begin
                        idx_d[d]  = '0;
                        lim_d[d]  = (dim_size[d*SW +: SW] == '0) ? '0
                                                                 : dim_size[d*SW +: SW] - 1'b1;
                        step_d[d] = {{(AW-STW){dim_step[d*STW+STW-1]}}, dim_step[d*STW +: STW]};
                        rb_d[d]   = base;
                    end
                    upd     = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                // A beat accepted together with abort still counts; nothing follows it.
                if (abort || (s_ready && last_q)) begin
                    state_d = IDLE;
                end else if (s_ready && carry_found) begin
                    // Carry: lower dims restart at 0, and their row-bases take the new address.
                    for (int d = 0; d < NDIM; d++) begin
                        if (d < k_sel) begin
                            idx_d[d] = '0;
                            rb_d[d]  = nxt_addr;
                        end else if (d == k_sel) begin
                            idx_d[d] = idx_q[d] + 1'b1;
                            rb_d[d]  = nxt_addr;
                        end
                    end
                    upd = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Beat flags are derived from the indices of the beat about to be presented.
        if (upd) begin
            first_d = 1'b1;
            for (int d = 0; d < NDIM; d++) begin
                if (idx_d[d] != '0) first_d = 1'b0;
                fin_acc    = fin_acc & (idx_d[d] == lim_d[d]);
                dlast_d[d] = fin_acc;
            end
            last_d = dlast_d[NDIM-1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge value of every other flop.
    // NOTE: the per-dimension arrays are small register files, not RAM, so they
    // are reset like any other flop to give defined outputs out of reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            for (int d = 0; d < NDIM; d++) begin
                idx_q[d]  <= '0;
                lim_q[d]  <= '0;
                step_q[d] <= '0;
                rb_q[d]   <= '0;
            end
            first_q <= 1'b0;
            last_q  <= 1'b0;
            dlast_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            lim_q   <= lim_d;
            step_q  <= step_d;
            rb_q    <= rb_d;
            first_q <= first_d;
            last_q  <= last_d;
            dlast_q <= dlast_d;
        end
    end

    assign start_ready = (state_q == IDLE);
    assign busy        = (state_q == RUN);
    assign s_valid     = (state_q == RUN);
    assign s_addr      = rb_q[0];
    assign s_first     = first_q;
    assign s_last      = last_q;
    assign s_dim_last  = dlast_q;

endmodule
